mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single memory wrapper between three requesters: port 0 (APB slave), port 1 (core data port) and port 2 (instruction fetch).
- Accepts one request at a time using round-robin arbitration.
- Drives the wrapper's enable, write/read, address, data and length signals for exactly one cycle per access.
- Returns a response (read data or write acknowledge, plus an error flag) to the owning port.

Parameters:
- DATA_LENGTH, 32, data bus width.
- ADDRESS_LENGTH, 32, address width.
- MEM_RD_LATENCY, 1, cycles from the read issue cycle to valid from_mem_data_out; legal range 1..7.

Ports:
- from_top_clk  in  1  clock.
- preset_n  in  1  reset; synchronous, active-low.
- req_valid  in  3  per-port request valid.
- req_write  in  3  per-port direction; 1 = write.
- req_addr  in  3*ADDRESS_LENGTH  per-port address; port i occupies bits [i*AL +: AL].
- req_wdata  in  3*DATA_LENGTH  per-port write data.
- req_len  in  6  per-port length, 2 bits each: 00 byte, 01 halfword, 11 word, 10 reserved.
- req_ready  out  3  per-port accept.
- rsp_valid  out  3  per-port one-cycle response strobe.
- rsp_rdata  out  DATA_LENGTH  read data, shared by all ports.
- rsp_err  out  1  error flag, qualified by any rsp_valid.
- to_mem_en  out  1  memory enable.
- to_mem_wr_en  out  1  memory write enable.
- to_mem_rd_en  out  1  memory read enable.
- to_mem_address  out  ADDRESS_LENGTH  memory address.
- to_mem_data_in  out  DATA_LENGTH  memory write data.
- to_mem_data_length  out  2  memory access length.
- from_mem_data_out  in  DATA_LENGTH  memory read data.

Behaviour:
- Single clock, from_top_clk. Synchronous active-low reset on preset_n.
- Reset state:
  - State = IDLE; all outputs 0.
  - last_grant = 2, so port 0 wins first.
  - Latched address/data/length/owner registers = 0.
- State machine has five states: IDLE, ISSUE, WAIT, RESP, ERR.
- IDLE:
  - Search order is (last_grant+1) mod 3, then +2, then +3.
  - The first port with req_valid=1 wins.
  - req_ready[winner]=1 combinationally in the same cycle; the other ready bits are 0.
  - On the next edge: latch the winner's write, addr, wdata and len plus owner; set last_grant = winner.
  - Next state is ERR if the access is misaligned, otherwise ISSUE.
  - Misaligned means: len=10; or len=01 with addr[0]=1; or len=11 with addr[1:0]≠0.
  - req_ready is 0 in every state other than IDLE.
- Requester rules:
  - A requester holds valid and its fields stable until it sees ready.
  - Deasserting valid before ready is allowed: the request is dropped and the arbiter is not affected.
- ISSUE (exactly 1 cycle):
  - to_mem_en=1; to_mem_wr_en=write; to_mem_rd_en=!write.
  - Address, data and length come from the latched registers.
  - Write → RESP.
  - Read → WAIT, with the counter loaded to MEM_RD_LATENCY-1.
- WAIT:
  - Memory enables are 0.
  - At the edge that ends the cycle where the counter = 0, capture from_mem_data_out into rsp_rdata. That is MEM_RD_LATENCY cycles after the ISSUE cycle.
  - Then → RESP.
  - With MEM_RD_LATENCY=1, WAIT lasts 1 cycle.
- RESP:
  - rsp_valid[owner]=1 for exactly 1 cycle; rsp_err=0.
  - rsp_rdata holds the captured read data. It is unchanged on writes.
  - Then → IDLE.
- ERR:
  - No memory access is made (to_mem_en stays 0).
  - rsp_valid[owner]=1 and rsp_err=1 for 1 cycle; rsp_rdata is unchanged.
  - Then → IDLE.
- Outside ISSUE: to_mem_en, to_mem_wr_en and to_mem_rd_en are 0. Address, data and length hold their last latched values, all from registers with no latches.
- Latency from the acceptance edge to rsp_valid:
  - Write: 2 cycles.
  - Read: 2+MEM_RD_LATENCY cycles.
  - Error: 1 cycle.
- Throughput: a new acceptance is possible in the cycle after RESP/ERR (back in IDLE).
- Simultaneous requests: exactly one grant per IDLE cycle. The losers keep waiting; no request is starved, because a port waits at most 2 other grants.
- A requester may present a new valid in the same cycle its rsp_valid is high. That request is considered in the following IDLE cycle.
- Reset mid-operation (any state):
  - Abort; return to IDLE; all outputs 0 on the next edge.
  - No response is issued for the in-flight request.
  - last_grant returns to 2.
- No combinational path from from_mem_data_out to any output.

Test Plan:
- Single write: port 1 writes addr 0x100, wdata 0xDEADBEEF, len 11.
  - → req_ready[1] pulses.
  - 1 cycle later: to_mem_en=1, wr_en=1, address 0x100, data 0xDEADBEEF for one cycle.
  - rsp_valid[1] pulses 2 cycles after acceptance, with rsp_err=0.
- Read, MEM_RD_LATENCY=1: port 2 reads 0x200 and the memory model returns 0x12345678.
  - → rd_en pulses one cycle.
  - rsp_valid[2] pulses 3 cycles after acceptance, with rsp_rdata=0x12345678.
- Round-robin: all three ports hold valid continuously from reset.
  - → grant order 0,1,2,0,1,2.
  - Each port gets exactly one rsp_valid per 3 transactions.
- Misaligned access: port 0 word access at 0x102, then halfword at 0x101, then len 10.
  - → the memory enables never assert.
  - Each request gets rsp_valid[0] with rsp_err=1, 1 cycle after acceptance.
- Latency parameter: MEM_RD_LATENCY=3; the memory model presents data only 3 cycles after rd_en.
  - → the data is captured correctly.
  - rsp_valid arrives 5 cycles after acceptance.
- Reset mid-read: preset_n=0 during WAIT for a port 1 read.
  - → next edge: all outputs 0 and no rsp_valid.
  - After release, with ports 0 and 1 both valid, port 0 is granted first.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one memory wrapper between the APB slave (port 0),
// the core data port (port 1) and instruction fetch (port 2). One access in flight at a time.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | searching ports round-robin from last_grant+1, ready to winner
// S_ISSUE | one-cycle memory strobe using latched request fields
// S_WAIT  | counting down read latency, capture read data at count 0
// S_RESP  | one-cycle response strobe to owner, rsp_err=0
// S_ERR   | misaligned request, one-cycle response strobe with rsp_err=1
module mem_port_arbiter #(
    parameter int DATA_LENGTH    = 32,
    parameter int ADDRESS_LENGTH = 32,
    parameter int MEM_RD_LATENCY = 1
) (
    input  logic                        from_top_clk,
    input  logic                        preset_n,
    input  logic [2:0]                  req_valid,
    input  logic [2:0]                  req_write,
    input  logic [3*ADDRESS_LENGTH-1:0] req_addr,
    input  logic [3*DATA_LENGTH-1:0]    req_wdata,
    input  logic [5:0]                  req_len,
    output logic [2:0]                  req_ready,
    output logic [2:0]                  rsp_valid,
    output logic [DATA_LENGTH-1:0]      rsp_rdata,
    output logic                        rsp_err,
    output logic                        to_mem_en,
    output logic                        to_mem_wr_en,
    output logic                        to_mem_rd_en,
    output logic [ADDRESS_LENGTH-1:0]   to_mem_address,
    output logic [DATA_LENGTH-1:0]      to_mem_data_in,
    output logic [1:0]                  to_mem_data_length,
    input  logic [DATA_LENGTH-1:0]      from_mem_data_out
);

    generate
        if (MEM_RD_LATENCY < 1 || MEM_RD_LATENCY > 7) begin : g_bad_latency
            $error("MEM_RD_LATENCY must be in 1..7");
        end
    endgenerate

    localparam logic [2:0] LAT_LOAD = 3'(MEM_RD_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [1:0]                last_grant_q;
    logic [1:0]                owner_q;
    logic                      write_q;
    logic [ADDRESS_LENGTH-1:0] addr_q;
    logic [DATA_LENGTH-1:0]    wdata_q;
    logic [1:0]                len_q;
    logic [2:0]                cnt_q;
    logic [DATA_LENGTH-1:0]    rdata_q;

    logic                      grant_vld;
    logic [1:0]                winner;
    logic [2:0]                cand;
    logic                      win_write;
    logic [ADDRESS_LENGTH-1:0] win_addr;
    logic [DATA_LENGTH-1:0]    win_wdata;
    logic [1:0]                win_len;
    logic                      win_misaligned;
    logic                      accept;

    // Search order starts one past the previous winner so every port waits at most two grants.
    always_comb begin
        grant_vld = 1'b0;
        winner    = 2'd0;
        cand      = 3'd0;
        for (int k = 1; k <= 3; k++) begin
            cand = {1'b0, last_grant_q} + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!grant_vld && req_valid[cand[1:0]]) begin
                grant_vld = 1'b1;
                winner    = cand[1:0];
            end
        end
    end

    always_comb begin
        win_write = req_write[0];
        win_addr  = req_addr[0 +: ADDRESS_LENGTH];
        win_wdata = req_wdata[0 +: DATA_LENGTH];
        win_len   = req_len[1:0];
        case (winner)
            2'd1: begin
                win_write = req_write[1];
                win_addr  = req_addr[ADDRESS_LENGTH +: ADDRESS_LENGTH];
                win_wdata = req_wdata[DATA_LENGTH +: DATA_LENGTH];
                win_len   = req_len[3:2];
            end
            2'd2: begin
                win_write = req_write[2];
                win_addr  = req_addr[2*ADDRESS_LENGTH +: ADDRESS_LENGTH];
                win_wdata = req_wdata[2*DATA_LENGTH +: DATA_LENGTH];
                win_len   = req_len[5:4];
            end
            default: ;
        endcase
    end

    assign win_misaligned = (win_len == 2'b10)
                          | ((win_len == 2'b01) & win_addr[0])
                          | ((win_len == 2'b11) & (|win_addr[1:0]));

    assign accept = (state_q == S_IDLE) && grant_vld;

    always_ff @(posedge from_top_clk) begin
        if (!preset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    state_d = win_misaligned ? S_ERR : S_ISSUE;
                end
            end
            S_ISSUE: state_d = write_q ? S_RESP : S_WAIT;
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready    = 3'b000;
        rsp_valid    = 3'b000;
        rsp_err      = 1'b0;
        to_mem_en    = 1'b0;
        to_mem_wr_en = 1'b0;
        to_mem_rd_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_vld && preset_n) begin
                    req_ready[winner] = 1'b1;
                end
            end
            S_ISSUE: begin
                to_mem_en    = 1'b1;
                to_mem_wr_en = write_q;
                to_mem_rd_en = !write_q;
            end
            S_RESP: rsp_valid[owner_q] = 1'b1;
            S_ERR: begin
                rsp_valid[owner_q] = 1'b1;
                rsp_err            = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge from_top_clk) begin
        if (!preset_n) begin
            last_grant_q <= 2'd2;
            owner_q      <= 2'd0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            len_q        <= 2'b00;
            cnt_q        <= 3'd0;
            rdata_q      <= '0;
        end else begin
            if (accept) begin
                last_grant_q <= winner;
                owner_q      <= winner;
                write_q      <= win_write;
                addr_q       <= win_addr;
                wdata_q      <= win_wdata;
                len_q        <= win_len;
            end
            if (state_q == S_ISSUE && !write_q) begin
                cnt_q <= LAT_LOAD;
            end
            if (state_q == S_WAIT) begin
                if (cnt_q == 3'd0) begin
                    rdata_q <= from_mem_data_out;
                end else begin
                    cnt_q <= cnt_q - 3'd1;
                end
            end
        end
    end

    assign rsp_rdata          = rdata_q;
    assign to_mem_address     = addr_q;
    assign to_mem_data_in     = wdata_q;
    assign to_mem_data_length = len_q;

endmodule
